// File: rtl/fake_n64_defs.sv
// Shared Joybus receiver definitions: command codes, FSM state encoding,
// bit-decoding thresholds and per-command frame lengths.
package fake_n64_defs;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_NONE   = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_DRAIN = 2'd3
  } rx_state_e;

  // A low period of at least this many clocks decodes as a 0
  function automatic int zero_thresh(input int clks_per_us);
    return 2 * clks_per_us;
  endfunction

  // A low period longer than this many clocks aborts the frame
  function automatic int err_thresh(input int clks_per_us);
    return 5 * clks_per_us;
  endfunction

  function automatic logic cmd_known(input logic [7:0] c);
    case (c)
      CMD_INFO, CMD_STATUS, CMD_READ, CMD_WRITE, CMD_RESET: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

  // Data bits in a frame (stop bit excluded)
  function automatic logic [8:0] frame_bits(input logic [7:0] c, input int max_bytes);
    case (c)
      CMD_INFO, CMD_STATUS, CMD_RESET: return 9'd8;
      CMD_READ:                        return 9'd24;
      CMD_WRITE:                       return 9'(24 + 8 * max_bytes);
      default:                         return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/fake_n64_bit_decoder.sv
// Synchronises the Joybus line, detects edges and measures low/high periods,
// reporting one decoded bit per low pulse plus abort conditions.
module fake_n64_bit_decoder
  import fake_n64_defs::*;
#(
  parameter int CLKS_PER_US = 4,
  parameter int IDLE_US     = 6
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_fall,
  output logic o_bit_valid,
  output logic o_bit_value,
  output logic o_pulse_err,
  output logic o_idle_timeout
);

  localparam logic [15:0] ZERO_C = 16'(zero_thresh(CLKS_PER_US));
  localparam logic [15:0] ERR_C  = 16'(err_thresh(CLKS_PER_US));
  localparam logic [15:0] IDLE_C = 16'(IDLE_US * CLKS_PER_US);

  logic        r_sync1, r_sync2, r_prev;
  logic [1:0]  r_vld;
  logic        r_low_active;
  logic [15:0] r_low_cnt, r_high_cnt;
  logic        r_fall, r_bit_valid, r_bit_value, r_pulse_err;
  logic        w_fall, w_rise;

  // r_prev only tracks real samples, so a line already low at reset release shows no fall
  assign w_fall = r_vld[1] & r_prev & ~r_sync2;
  assign w_rise = r_vld[1] & ~r_prev & r_sync2;

  // Synchroniser, edge history and low/high period counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_prev       <= 1'b0;
      r_vld        <= 2'b00;
      r_low_active <= 1'b0;
      r_low_cnt    <= 16'd0;
      r_high_cnt   <= 16'd0;
      r_fall       <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_bit_value  <= 1'b0;
      r_pulse_err  <= 1'b0;
    end else begin
      r_sync1     <= i_line;
      r_sync2     <= r_sync1;
      r_vld       <= {r_vld[0], 1'b1};
      r_prev      <= r_vld[1] & r_sync2;
      r_fall      <= w_fall;
      r_bit_valid <= 1'b0;
      r_pulse_err <= 1'b0;
      if (w_fall) begin
        r_low_active <= 1'b1;
        r_low_cnt    <= 16'd1;
        r_high_cnt   <= 16'd0;
      end else if (w_rise) begin
        r_bit_valid  <= r_low_active;
        r_bit_value  <= (r_low_cnt < ZERO_C);
        r_low_active <= 1'b0;
        r_low_cnt    <= 16'd0;
        r_high_cnt   <= 16'd1;
      end else if (r_vld[1] && !r_sync2 && r_low_active) begin
        r_low_cnt <= r_low_cnt + 16'd1;
        if (r_low_cnt == ERR_C) begin
          r_pulse_err  <= 1'b1;
          r_low_active <= 1'b0;
        end
      end else if (r_vld[1] && r_sync2 && (r_high_cnt != IDLE_C)) begin
        r_high_cnt <= r_high_cnt + 16'd1;
      end
    end
  end

  assign o_fall         = r_fall;
  assign o_bit_valid    = r_bit_valid;
  assign o_bit_value    = r_bit_value;
  assign o_pulse_err    = r_pulse_err;
  assign o_idle_timeout = (r_high_cnt == IDLE_C);

endmodule

// File: rtl/fake_n64_joybus_rx.sv
// Joybus frame receiver: assembles decoded bits into command, address and
// write-payload bytes and flags well-formed or aborted frames.
module fake_n64_joybus_rx
  import fake_n64_defs::*;
#(
  parameter int CLKS_PER_US    = 4,
  parameter int MAX_DATA_BYTES = 32,
  parameter int IDLE_US        = 6
) (
  input  logic        sample_clk,
  input  logic        reset_n,
  input  logic        data_rx,
  output logic [7:0]  cmd,
  output logic [15:0] address,
  output logic        wr_strobe,
  output logic [7:0]  wr_data,
  output logic [4:0]  wr_index,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        busy
);

  logic w_fall, w_bit_valid, w_bit_value, w_pulse_err, w_idle_timeout;

  fake_n64_bit_decoder #(
    .CLKS_PER_US(CLKS_PER_US),
    .IDLE_US    (IDLE_US)
  ) u_dec (
    .i_clk         (sample_clk),
    .i_rst_n       (reset_n),
    .i_line        (data_rx),
    .o_fall        (w_fall),
    .o_bit_valid   (w_bit_valid),
    .o_bit_value   (w_bit_value),
    .o_pulse_err   (w_pulse_err),
    .o_idle_timeout(w_idle_timeout)
  );

  rx_state_e   r_state, w_state_nxt;
  logic [8:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [15:0] r_shift, w_shift_nxt, w_shifted;
  logic [7:0]  r_cmd, w_cmd_nxt;
  logic [15:0] r_address, w_address_nxt;
  logic        r_wr_strobe, w_wr_strobe_nxt;
  logic [7:0]  r_wr_data, w_wr_data_nxt;
  logic [4:0]  r_wr_index, w_wr_index_nxt, r_byte_idx, w_byte_idx_nxt;
  logic        r_frame_valid, w_frame_valid_nxt, r_frame_error, w_frame_error_nxt;
  logic        r_busy, w_busy_nxt;
  logic [8:0]  w_cnt_inc, w_len;

  assign w_shifted = {r_shift[14:0], w_bit_value};
  assign w_cnt_inc = r_bit_cnt + 9'd1;
  assign w_len     = frame_bits(r_cmd, MAX_DATA_BYTES);

  // FSM state register
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_shift_nxt       = r_shift;
    w_cmd_nxt         = r_cmd;
    w_address_nxt     = r_address;
    w_wr_strobe_nxt   = 1'b0;
    w_wr_data_nxt     = r_wr_data;
    w_wr_index_nxt    = r_wr_index;
    w_byte_idx_nxt    = r_byte_idx;
    w_frame_valid_nxt = 1'b0;
    w_frame_error_nxt = 1'b0;
    w_busy_nxt        = r_busy;
    case (r_state)
      ST_IDLE: begin
        w_bit_cnt_nxt  = 9'd0;
        w_byte_idx_nxt = 5'd0;
        if (w_fall) begin
          w_state_nxt = ST_LOW;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (w_pulse_err) begin
          w_frame_error_nxt = 1'b1;
          w_state_nxt       = ST_DRAIN;
        end else if (w_bit_valid) begin
          // Once all data bits are in, the next pulse is the stop bit
          if ((r_bit_cnt >= 9'd8) && (r_bit_cnt == w_len)) begin
            w_frame_valid_nxt = w_bit_value;
            w_frame_error_nxt = ~w_bit_value;
            w_state_nxt       = ST_IDLE;
            w_busy_nxt        = 1'b0;
          end else begin
            w_shift_nxt   = w_shifted;
            w_bit_cnt_nxt = w_cnt_inc;
            w_state_nxt   = ST_HIGH;
            if (w_cnt_inc == 9'd8) begin
              w_cmd_nxt = w_shifted[7:0];
              if (!cmd_known(w_shifted[7:0])) begin
                w_frame_error_nxt = 1'b1;
                w_state_nxt       = ST_DRAIN;
              end else begin
                w_state_nxt = ST_HIGH;
              end
            end else if ((w_cnt_inc == 9'd24) && ((r_cmd == CMD_READ) || (r_cmd == CMD_WRITE))) begin
              w_address_nxt = w_shifted;
            end else if ((w_cnt_inc > 9'd24) && (w_cnt_inc[2:0] == 3'd0) && (r_cmd == CMD_WRITE)) begin
              w_wr_strobe_nxt = 1'b1;
              w_wr_data_nxt   = w_shifted[7:0];
              w_wr_index_nxt  = r_byte_idx;
              w_byte_idx_nxt  = r_byte_idx + 5'd1;
            end else begin
              w_wr_strobe_nxt = 1'b0;
            end
          end
        end else begin
          w_state_nxt = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (w_fall) begin
          w_state_nxt = ST_LOW;
        end else if (w_idle_timeout) begin
          w_frame_error_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
          w_busy_nxt        = 1'b0;
        end else begin
          w_state_nxt = ST_HIGH;
        end
      end
      ST_DRAIN: begin
        if (w_idle_timeout) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt     <= 9'd0;
      r_shift       <= 16'd0;
      r_cmd         <= CMD_NONE;
      r_address     <= 16'd0;
      r_wr_strobe   <= 1'b0;
      r_wr_data     <= 8'd0;
      r_wr_index    <= 5'd0;
      r_byte_idx    <= 5'd0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_cmd         <= w_cmd_nxt;
      r_address     <= w_address_nxt;
      r_wr_strobe   <= w_wr_strobe_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_wr_index    <= w_wr_index_nxt;
      r_byte_idx    <= w_byte_idx_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign cmd         = r_cmd;
  assign address     = r_address;
  assign wr_strobe   = r_wr_strobe;
  assign wr_data     = r_wr_data;
  assign wr_index    = r_wr_index;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fake_n64_joybus_rx.sv
// Directed bench for the Joybus receiver at CLKS_PER_US=4 ('0'=12/4, '1'=4/12, stop=4 low).
module tb_fake_n64_joybus_rx;

  logic        sample_clk = 1'b0;
  logic        reset_n;
  logic        data_rx;
  logic [7:0]  cmd;
  logic [15:0] address;
  logic        wr_strobe;
  logic [7:0]  wr_data;
  logic [4:0]  wr_index;
  logic        frame_valid, frame_error, busy;

  int checks   = 0;
  int failures = 0;

  fake_n64_joybus_rx #(
    .CLKS_PER_US   (4),
    .MAX_DATA_BYTES(32),
    .IDLE_US       (6)
  ) dut (
    .sample_clk (sample_clk),
    .reset_n    (reset_n),
    .data_rx    (data_rx),
    .cmd        (cmd),
    .address    (address),
    .wr_strobe  (wr_strobe),
    .wr_data    (wr_data),
    .wr_index   (wr_index),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 sample_clk = ~sample_clk;

  // Pulse monitor sampled on the inactive edge
  int         fv_total = 0, fe_total = 0, wr_total = 0, both_total = 0;
  logic [7:0] wr_data_log [0:63];
  logic [4:0] wr_idx_log  [0:63];

  always @(negedge sample_clk) begin
    if (frame_valid) fv_total <= fv_total + 1;
    if (frame_error) fe_total <= fe_total + 1;
    if (frame_valid && frame_error) both_total <= both_total + 1;
    if (wr_strobe) begin
      wr_data_log[wr_total % 64] <= wr_data;
      wr_idx_log[wr_total % 64]  <= wr_index;
      wr_total <= wr_total + 1;
    end
  end

  int fv0, fe0, wr0;

  task automatic snap();
    fv0 = fv_total;
    fe0 = fe_total;
    wr0 = wr_total;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sample_clk);
  endtask

  task automatic send_bit_lh(input int lo, input int hi);
    data_rx = 1'b0;
    wait_cyc(lo);
    data_rx = 1'b1;
    wait_cyc(hi);
  endtask

  task automatic send_bit(input logic v);
    if (v) send_bit_lh(4, 12);
    else   send_bit_lh(12, 4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_stop();
    send_bit_lh(4, 10);
  endtask

  initial begin
    int bad;
    logic [7:0] pat;

    // Reset values
    data_rx = 1'b1;
    reset_n = 1'b0;
    wait_cyc(3);
    chk("rst_cmd", cmd, 32'hFE);
    chk("rst_address", address, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_wr_index", wr_index, 32'h0);
    chk("rst_wr_strobe", wr_strobe, 32'h0);
    chk("rst_valid", frame_valid, 32'h0);
    chk("rst_error", frame_error, 32'h0);
    chk("rst_busy", busy, 32'h0);
    reset_n = 1'b1;
    wait_cyc(10);

    // STATUS frame with exact stop-bit latency
    snap();
    send_byte(8'h01);
    chk("status_busy_mid", busy, 32'h1);
    data_rx = 1'b0;
    wait_cyc(4);
    data_rx = 1'b1;
    wait_cyc(3);
    chk("status_fv_early", frame_valid, 32'h0);
    wait_cyc(1);
    chk("status_fv_latency", frame_valid, 32'h1);
    chk("status_busy_drop", busy, 32'h0);
    wait_cyc(8);
    chk("status_cmd", cmd, 32'h01);
    chk("status_fv_count", fv_total - fv0, 32'd1);
    chk("status_fe_count", fe_total - fe0, 32'd0);
    chk("status_no_wr", wr_total - wr0, 32'd0);

    // READ frame
    snap();
    send_byte(8'h02);
    send_byte(8'h80);
    send_byte(8'h01);
    send_stop();
    chk("read_cmd", cmd, 32'h02);
    chk("read_address", address, 32'h8001);
    chk("read_fv_count", fv_total - fv0, 32'd1);
    chk("read_busy", busy, 32'h0);

    // WRITE frame with 32 payload bytes
    snap();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h20);
    for (int i = 0; i < 32; i++) begin
      pat = 8'(i);
      send_byte(pat);
    end
    send_stop();
    chk("write_cmd", cmd, 32'h03);
    chk("write_address", address, 32'h0020);
    chk("write_strobes", wr_total - wr0, 32'd32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (wr_data_log[(wr0 + i) % 64] !== 8'(i) || wr_idx_log[(wr0 + i) % 64] !== 5'(i)) bad++;
    end
    chk("write_payload_seq", bad, 32'd0);
    chk("write_fv_count", fv_total - fv0, 32'd1);
    chk("write_fe_count", fe_total - fe0, 32'd0);

    // Unknown command 0x42 aborts after bit 8 and drains
    snap();
    send_byte(8'h42);
    wait_cyc(2);
    chk("badcmd_fe", fe_total - fe0, 32'd1);
    chk("badcmd_cmd", cmd, 32'h42);
    chk("badcmd_draining", busy, 32'h1);
    wait_cyc(40);
    chk("badcmd_drained", busy, 32'h0);
    chk("badcmd_fv_none", fv_total - fv0, 32'd0);
    snap();
    send_byte(8'h00);
    send_stop();
    chk("after_drain_cmd", cmd, 32'h00);
    chk("after_drain_fv", fv_total - fv0, 32'd1);

    // READ truncated after 10 address bits: idle timeout
    snap();
    send_byte(8'h02);
    send_byte(8'hAA);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_cyc(40);
    chk("trunc_fe", fe_total - fe0, 32'd1);
    chk("trunc_fv", fv_total - fv0, 32'd0);
    chk("trunc_address_held", address, 32'h0020);
    chk("trunc_busy", busy, 32'h0);

    // Overlong low pulse aborts
    snap();
    send_bit_lh(30, 40);
    chk("longlow_fe", fe_total - fe0, 32'd1);
    chk("longlow_busy", busy, 32'h0);

    // Threshold edges: 7 low decodes 1, 8 and 20 low decode 0
    snap();
    for (int i = 0; i < 8; i++) send_bit_lh(7, 9);
    send_stop();
    chk("thr7_cmd", cmd, 32'hFF);
    for (int i = 0; i < 8; i++) send_bit_lh(8, 8);
    send_stop();
    chk("thr8_cmd", cmd, 32'h00);
    for (int i = 0; i < 8; i++) send_bit_lh(20, 4);
    send_stop();
    chk("thr20_cmd", cmd, 32'h00);
    chk("thr_fv_count", fv_total - fv0, 32'd3);
    chk("thr_fe_count", fe_total - fe0, 32'd0);

    // Reset in the middle of a WRITE payload
    snap();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_bit(1'b1);
    send_bit(1'b0);
    data_rx = 1'b0;
    wait_cyc(2);
    reset_n = 1'b0;
    data_rx = 1'b1;
    wait_cyc(1);
    chk("midrst_cmd", cmd, 32'hFE);
    chk("midrst_address", address, 32'h0);
    chk("midrst_wr_data", wr_data, 32'h0);
    chk("midrst_wr_index", wr_index, 32'h0);
    chk("midrst_busy", busy, 32'h0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(40);
    chk("midrst_no_fe", fe_total - fe0, 32'd0);
    snap();
    send_byte(8'hFF);
    send_stop();
    chk("midrst_next_cmd", cmd, 32'hFF);
    chk("midrst_next_fv", fv_total - fv0, 32'd1);

    // Line held low across reset release must not start a frame
    snap();
    reset_n = 1'b0;
    data_rx = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    chk("lowrst_busy_low", busy, 32'h0);
    data_rx = 1'b1;
    wait_cyc(40);
    chk("lowrst_busy_high", busy, 32'h0);
    chk("lowrst_no_fe", fe_total - fe0, 32'd0);
    send_byte(8'h01);
    send_stop();
    chk("lowrst_next_fv", fv_total - fv0, 32'd1);

    chk("never_both", both_total, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
